// File: rtl/timer_ctrl.sv
// Programmable timer: TIMA counts falling edges of a divider tap selected by TAC,
// and on overflow reloads from TMA after a fixed delay and raises a one-cycle irq.
module timer_ctrl #(
  parameter int unsigned RELOAD_DELAY = 4,
  parameter int unsigned DIV_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 sel,
  input  logic [1:0]           addr,
  input  logic                 wr,
  input  logic                 rd,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic                 div_reset,
  output logic                 irq
);

  localparam int unsigned CW = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;

  typedef enum logic [1:0] {RUN, WAIT, RELOAD} state_t;

  state_t        state, state_nxt;
  logic [7:0]    tima, tima_nxt;
  logic [7:0]    tma;
  logic [2:0]    tac;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tick, tick_q, tap, inc;
  logic          wr_div, wr_tima, wr_tma, wr_tac;
  logic          unused_div;

  assign unused_div = ^div;

  always_comb begin
    wr_div  = sel && wr && (addr == 2'd0);
    wr_tima = sel && wr && (addr == 2'd1);
    wr_tma  = sel && wr && (addr == 2'd2);
    wr_tac  = sel && wr && (addr == 2'd3);
  end

  always_comb begin
    tap = 1'b0;
    case (tac[1:0])
      2'b00: tap = div[9];
      2'b01: tap = div[3];
      2'b10: tap = div[5];
      2'b11: tap = div[7];
      default: tap = 1'b0;
    endcase
    tick = tac[2] & tap;
    // A TAC write or divider clear that drops the tick counts as a real edge.
    inc  = tick_q & ~tick;
  end

  // State register together with the datapath it sequences.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= RUN;
      tima      <= '0;
      cnt       <= '0;
      tma       <= '0;
      tac       <= '0;
      tick_q    <= 1'b0;
      div_reset <= 1'b0;
    end else begin
      state     <= state_nxt;
      tima      <= tima_nxt;
      cnt       <= cnt_nxt;
      tick_q    <= tick;
      div_reset <= wr_div;
      if (wr_tma) tma <= din;
      if (wr_tac) tac <= din[2:0];
    end
  end

  always_comb begin
    state_nxt = state;
    tima_nxt  = tima;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (wr_tima) begin
          tima_nxt = din;
        end else if (inc) begin
          if (tima == 8'hFF) begin
            tima_nxt  = '0;
            cnt_nxt   = CW'(RELOAD_DELAY - 1);
            state_nxt = WAIT;
          end else begin
            tima_nxt = tima + 8'd1;
          end
        end
      end
      WAIT: begin
        if (wr_tima) begin
          tima_nxt  = din;
          state_nxt = RUN;
        end else if (cnt == '0) begin
          tima_nxt  = tma;
          state_nxt = RELOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RELOAD: begin
        state_nxt = RUN;
        // TIMA writes are swallowed here, but a TMA write also lands in TIMA.
        if (wr_tma) tima_nxt = din;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    irq = (state == RELOAD);
  end

  always_comb begin
    dout = '0;
    if (sel && rd) begin
      case (addr)
        2'd0: dout = div[15:8];
        2'd1: dout = tima;
        2'd2: dout = tma;
        2'd3: dout = {5'b11111, tac};
        default: dout = '0;
      endcase
    end
  end

endmodule
